zrb_uart_rx_os: RTL and testbench

ZRB_UART_RX_OS -- requirements
Module: zrb_uart_rx_os

---
 rtl/zrb_uart_rx_os.sv | 84 ++++++++
 tb/tb_zrb_uart_rx_os.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/zrb_uart_rx_os.sv
// zrb_uart_rx_os: oversampled 8N1 UART receiver with framing-error detection and break handling
module zrb_uart_rx_os #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      sh_q;
  logic [7:0]      data_q;
  logic            ready_q;
  logic            ferr_q;
  logic            meta_q;
  logic            rx_s_q;
  logic            half;
  logic            full;
  assign half      = cnt_q == CW'(OVERSAMPLE / 2 - 1);
  assign full      = cnt_q == CW'(OVERSAMPLE - 1);
  assign data_out  = data_q;
  assign ready     = ready_q;
  assign frame_err = ferr_q;
  assign busy      = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      meta_q  <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      meta_q  <= rx;
      rx_s_q  <= meta_q;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (tick) begin
        case (state_q)
          IDLE: if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
          // validate the start bit at its midpoint to reject short glitches
          START: if (half) begin
            state_q <= rx_s_q ? IDLE : DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
          DATA: begin
            cnt_q <= cnt_q + 1'b1;
            if (full) begin
              sh_q[idx_q] <= rx_s_q;
              idx_q       <= idx_q + 1'b1;
              if (idx_q == 3'd7) state_q <= STOP;
            end
          end
          STOP: begin
            cnt_q <= cnt_q + 1'b1;
            if (full) begin
              state_q <= rx_s_q ? IDLE : WAIT_HIGH;
              ready_q <= rx_s_q;
              ferr_q  <= !rx_s_q;
              if (rx_s_q) data_q <= sh_q;
            end
          end
          WAIT_HIGH: if (rx_s_q) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_zrb_uart_rx_os.sv
// tb_zrb_uart_rx_os: directed and randomized frame checks against a byte-level reference model
module tb_zrb_uart_rx_os;
  localparam int BITCLK = 32;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       ready;
  logic       frame_err;
  logic       busy;
  logic [1:0] tdiv = 2'd0;
  int         pass_cnt = 0;
  int         tot = 0;
  int         rdy_cnt = 0;
  int         ferr_cnt = 0;
  int         viol = 0;
  int         busy_seen = 0;
  logic       prev_rdy = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] got [0:255];

  zrb_uart_rx_os #(.OVERSAMPLE(8)) dut (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx),
    .data_out(data_out), .ready(ready), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tdiv <= tdiv + 2'd1;
    tick <= tdiv == 2'd3;
  end

  always @(negedge clk) begin
    if (ready) begin
      got[rdy_cnt[7:0]] <= data_out;
      rdy_cnt <= rdy_cnt + 1;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if ((ready && frame_err) || (ready && prev_rdy) || (frame_err && prev_ferr)) viol <= viol + 1;
    if (busy) busy_seen <= busy_seen + 1;
    prev_rdy  <= ready;
    prev_ferr <= frame_err;
  end

  task automatic send_bits(input logic b, input int nbits);
    rx = b;
    repeat (nbits * BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) send_bits(d[i], 1);
    send_bits(stop, 1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (8) @(negedge clk);
    tot++; if (data_out !== 8'h00) $display("FAIL reset_data got=%h exp=00", data_out); else pass_cnt++;
    tot++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else pass_cnt++;
    tot++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", frame_err); else pass_cnt++;
    tot++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    reset = 1'b0;
    send_bits(1'b1, 2);
    tot++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_basic;
    int r0, f0;
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    send_bits(1'b1, 1);
    tot++; if (rdy_cnt - r0 !== 1) $display("FAIL basic_ready_count got=%0d exp=1", rdy_cnt - r0); else pass_cnt++;
    tot++; if (got[r0[7:0]] !== 8'hA5) $display("FAIL basic_byte got=%h exp=a5", got[r0[7:0]]); else pass_cnt++;
    tot++; if (data_out !== 8'hA5) $display("FAIL basic_data got=%h exp=a5", data_out); else pass_cnt++;
    tot++; if (ferr_cnt - f0 !== 0) $display("FAIL basic_ferr got=%0d exp=0", ferr_cnt - f0); else pass_cnt++;
    tot++; if (busy !== 1'b0) $display("FAIL basic_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int r0, f0, b0;
    logic [7:0] d0;
    r0 = rdy_cnt; f0 = ferr_cnt; b0 = busy_seen; d0 = data_out;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    send_bits(1'b1, 2);
    tot++; if (!(busy_seen > b0)) $display("FAIL glitch_start_seen got=%0d exp>%0d", busy_seen, b0); else pass_cnt++;
    tot++; if (rdy_cnt - r0 !== 0) $display("FAIL glitch_ready got=%0d exp=0", rdy_cnt - r0); else pass_cnt++;
    tot++; if (ferr_cnt - f0 !== 0) $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); else pass_cnt++;
    tot++; if (data_out !== d0) $display("FAIL glitch_data got=%h exp=%h", data_out, d0); else pass_cnt++;
    tot++; if (busy !== 1'b0) $display("FAIL glitch_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_frame_err;
    int r0, f0;
    logic [7:0] d0;
    r0 = rdy_cnt; f0 = ferr_cnt; d0 = data_out;
    send_frame(8'h3C, 1'b0);
    tot++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); else pass_cnt++;
    tot++; if (busy !== 1'b1) $display("FAIL ferr_wait_busy got=%b exp=1", busy); else pass_cnt++;
    send_bits(1'b1, 1);
    tot++; if (busy !== 1'b0) $display("FAIL ferr_idle_busy got=%b exp=0", busy); else pass_cnt++;
    tot++; if (data_out !== d0) $display("FAIL ferr_data_kept got=%h exp=%h", data_out, d0); else pass_cnt++;
    tot++; if (rdy_cnt - r0 !== 0) $display("FAIL ferr_ready got=%0d exp=0", rdy_cnt - r0); else pass_cnt++;
    send_frame(8'h11, 1'b1);
    send_bits(1'b1, 1);
    tot++; if (rdy_cnt - r0 !== 1) $display("FAIL ferr_next_ready got=%0d exp=1", rdy_cnt - r0); else pass_cnt++;
    tot++; if (data_out !== 8'h11) $display("FAIL ferr_next_data got=%h exp=11", data_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int r0;
    r0 = rdy_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_bits(1'b1, 1);
    tot++; if (rdy_cnt - r0 !== 2) $display("FAIL b2b_count got=%0d exp=2", rdy_cnt - r0); else pass_cnt++;
    tot++; if (got[r0[7:0]] !== 8'h55) $display("FAIL b2b_first got=%h exp=55", got[r0[7:0]]); else pass_cnt++;
    tot++; if (got[r0[7:0] + 8'd1] !== 8'hAA) $display("FAIL b2b_second got=%h exp=aa", got[r0[7:0] + 8'd1]); else pass_cnt++;
    tot++; if (data_out !== 8'hAA) $display("FAIL b2b_data got=%h exp=aa", data_out); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int r0, f0;
    r0 = rdy_cnt; f0 = ferr_cnt;
    send_bits(1'b0, 1);
    send_bits(1'b1, 4);
    repeat (BITCLK / 2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (BITCLK / 2) @(negedge clk);
    send_bits(1'b1, 5);
    tot++; if (rdy_cnt - r0 !== 0) $display("FAIL rstmid_ready got=%0d exp=0", rdy_cnt - r0); else pass_cnt++;
    tot++; if (ferr_cnt - f0 !== 0) $display("FAIL rstmid_ferr got=%0d exp=0", ferr_cnt - f0); else pass_cnt++;
    tot++; if (data_out !== 8'h00) $display("FAIL rstmid_data got=%h exp=00", data_out); else pass_cnt++;
    tot++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else pass_cnt++;
    send_frame(8'h00, 1'b1);
    send_bits(1'b1, 1);
    tot++; if (rdy_cnt - r0 !== 1) $display("FAIL rstmid_next_ready got=%0d exp=1", rdy_cnt - r0); else pass_cnt++;
    tot++; if (got[r0[7:0]] !== 8'h00) $display("FAIL rstmid_next_data got=%h exp=00", got[r0[7:0]]); else pass_cnt++;
  endtask

  task automatic test_break;
    int r0, f0;
    logic [7:0] d0;
    send_frame(8'h6E, 1'b1);
    send_bits(1'b1, 1);
    r0 = rdy_cnt; f0 = ferr_cnt; d0 = data_out;
    send_bits(1'b0, 20);
    tot++; if (ferr_cnt - f0 !== 1) $display("FAIL break_ferr got=%0d exp=1", ferr_cnt - f0); else pass_cnt++;
    tot++; if (busy !== 1'b1) $display("FAIL break_busy_low got=%b exp=1", busy); else pass_cnt++;
    tot++; if (rdy_cnt - r0 !== 0) $display("FAIL break_ready got=%0d exp=0", rdy_cnt - r0); else pass_cnt++;
    send_bits(1'b1, 1);
    tot++; if (busy !== 1'b0) $display("FAIL break_busy_high got=%b exp=0", busy); else pass_cnt++;
    tot++; if (data_out !== d0) $display("FAIL break_data got=%h exp=%h", data_out, d0); else pass_cnt++;
  endtask

  task automatic test_random;
    int r0, f0, n, fe, gap;
    logic [7:0] exp_q [0:31];
    logic [7:0] d, last;
    logic bad;
    r0 = rdy_cnt; f0 = ferr_cnt; n = 0; fe = 0; last = data_out;
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      bad = $urandom_range(0, 4) == 0;
      gap = bad ? $urandom_range(1, 2) : $urandom_range(0, 2);
      send_frame(d, !bad);
      if (bad) fe++;
      else begin
        exp_q[n] = d;
        n++;
        last = d;
      end
      send_bits(1'b1, gap);
      if (gap > 0) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    send_bits(1'b1, 1);
    tot++; if (rdy_cnt - r0 !== n) $display("FAIL rand_ready_count got=%0d exp=%0d", rdy_cnt - r0, n); else pass_cnt++;
    tot++; if (ferr_cnt - f0 !== fe) $display("FAIL rand_ferr_count got=%0d exp=%0d", ferr_cnt - f0, fe); else pass_cnt++;
    for (int k = 0; k < n; k++) begin
      tot++;
      if (got[8'(r0 + k)] !== exp_q[k]) $display("FAIL rand_byte%0d got=%h exp=%h", k, got[8'(r0 + k)], exp_q[k]);
      else pass_cnt++;
    end
    tot++; if (data_out !== last) $display("FAIL rand_data got=%h exp=%h", data_out, last); else pass_cnt++;
    tot++; if (viol !== 0) $display("FAIL pulse_shape got=%0d exp=0", viol); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_break;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
